hazard_fwd_unit: RTL and testbench

- Combined forwarding and hazard unit for the 5-stage RV pipeline (IF/ID/EX/MEM/WB).
- Generates ALU operand and store-data bypass selects for EX.
- Detects load-use and multi-cycle-unit (MUL/DIV) RAW/WAW hazards in ID using a per-register scoreboard, and drives stall/bubble controls.
- Adds a saturating stall-cycle performance counter and a multi-cycle timeout watchdog.

---
 rtl/pipe_pkg.sv | 11 +
 rtl/mc_scoreboard.sv | 59 +++++
 rtl/hazard_fwd_unit.sv | 105 ++++++++++
 tb/tb_hazard_fwd_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared bypass select codes and register-file geometry defaults
package pipe_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int DEF_REG_AW = 5;
  localparam int DEF_NREGS  = 32;

endpackage

// File: rtl/mc_scoreboard.sv
// rtl/mc_scoreboard.sv - multi-cycle op pending bits, outstanding count and stuck-op watchdog
module mc_scoreboard
  import pipe_pkg::*;
#(
  parameter int REG_AW      = DEF_REG_AW,
  parameter int NREGS       = DEF_NREGS,
  parameter int MAX_MC      = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int OUT_W       = $clog2(MAX_MC + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mcStart,
  input  logic [REG_AW-1:0] mcStartRd,
  input  logic              mcDone,
  input  logic [REG_AW-1:0] mcDoneRd,
  output logic [NREGS-1:0]  pending,
  output logic [OUT_W-1:0]  outstanding,
  output logic              mcTimeout
);

  localparam int              WD_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);

  logic [WD_W-1:0]  wdCnt;
  logic [NREGS-1:0] pendingNxt;
  logic             doneValid;

  // A completion with nothing outstanding is spurious and leaves all state alone.
  assign doneValid = mcDone && (outstanding != '0);

  always_comb begin
    pendingNxt = pending;
    if (doneValid) pendingNxt[mcDoneRd] = 1'b0;
    if (mcStart && (mcStartRd != '0)) pendingNxt[mcStartRd] = 1'b1;
    pendingNxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      outstanding <= '0;
      wdCnt       <= '0;
      mcTimeout   <= 1'b0;
    end else begin
      pending <= pendingNxt;
      if (mcStart && !doneValid && (outstanding != '1)) outstanding <= outstanding + OUT_W'(1);
      else if (!mcStart && doneValid) outstanding <= outstanding - OUT_W'(1);
      // Watchdog measures consecutive cycles with work in flight and no progress.
      if ((outstanding == '0) || mcDone) begin
        wdCnt <= '0;
      end else begin
        if (wdCnt != WD_LIMIT) wdCnt <= wdCnt + WD_W'(1);
        if (wdCnt >= (WD_LIMIT - WD_W'(1))) mcTimeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - EX operand bypass selects and ID stall/bubble generation
module hazard_fwd_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW      = DEF_REG_AW,
  parameter int NREGS       = DEF_NREGS,
  parameter int FWD_EN      = 1,
  parameter int MAX_MC      = 2,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              id_reg_write,
  input  logic              id_mc_op,
  input  logic              id_kill,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_alusrc,
  input  logic              ex_mc_start,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic              mc_done,
  input  logic [REG_AW-1:0] mc_rd,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic [1:0]        forward_c,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              mc_busy,
  output logic              mc_timeout,
  output logic [CNT_W-1:0]  stall_cycles,
  input  logic              perf_clr
);

  localparam int OUT_W = $clog2(MAX_MC + 2);

  logic [NREGS-1:0] pending;
  logic [OUT_W-1:0] outstanding;
  logic             hzLoadUse, hzMcIssue, hzScoreboard, hzFull, hzNoFwd, stall;

  mc_scoreboard #(
    .REG_AW(REG_AW), .NREGS(NREGS), .MAX_MC(MAX_MC),
    .TIMEOUT_CYC(TIMEOUT_CYC), .OUT_W(OUT_W)
  ) uScoreboard (
    .clk(clk), .rst_n(rst_n),
    .mcStart(ex_mc_start), .mcStartRd(ex_rd),
    .mcDone(mc_done), .mcDoneRd(mc_rd),
    .pending(pending), .outstanding(outstanding), .mcTimeout(mc_timeout)
  );

  function automatic logic [1:0] bypassSel(input logic [REG_AW-1:0] rs, input logic enable);
    if (FWD_EN == 0 || !enable) return FWD_REG;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs)) return FWD_MEM;
    if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) return FWD_WB;
    return FWD_REG;
  endfunction

  function automatic logic readsReg(input logic [REG_AW-1:0] r);
    return (r != '0) && ((id_rs1_used && (id_rs1 == r)) || (id_rs2_used && (id_rs2 == r)));
  endfunction

  assign forward_a = bypassSel(ex_rs1, 1'b1);
  assign forward_b = bypassSel(ex_rs2, !ex_alusrc);
  assign forward_c = bypassSel(ex_rs2, ex_mem_write);

  assign hzLoadUse    = ex_mem_read && readsReg(ex_rd);
  assign hzMcIssue    = ex_mc_start && (readsReg(ex_rd) || (id_reg_write && (id_rd == ex_rd)));
  assign hzScoreboard = (id_rs1_used && pending[id_rs1]) || (id_rs2_used && pending[id_rs2]) ||
                        (id_reg_write && pending[id_rd]);
  assign hzFull       = id_mc_op &&
                        (({1'b0, outstanding} + {{OUT_W{1'b0}}, ex_mc_start}) >= (OUT_W + 1)'(MAX_MC));
  // Without bypass paths every in-flight producer must drain through the register file.
  assign hzNoFwd      = (FWD_EN == 0) && ((ex_reg_write && readsReg(ex_rd)) ||
                        (mem_reg_write && readsReg(mem_rd)) || (wb_reg_write && readsReg(wb_rd)));

  assign stall     = !id_kill && (hzLoadUse || hzMcIssue || hzScoreboard || hzFull || hzNoFwd);
  assign stall_if  = stall;
  assign stall_id  = stall;
  assign bubble_ex = stall;
  assign mc_busy   = (outstanding != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (perf_clr) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - directed and randomized bench for hazard_fwd_unit
module tb_hazard_fwd_unit;

  localparam int MAXMC  = 2;
  localparam int CW     = 8;
  localparam int TMO    = 64;
  localparam int CNTMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd, mc_rd;
  logic id_rs1_used, id_rs2_used, id_reg_write, id_mc_op, id_kill;
  logic ex_reg_write, ex_mem_read, ex_mem_write, ex_alusrc, ex_mc_start;
  logic mem_reg_write, wb_reg_write, mc_done, perf_clr;

  logic [1:0] forward_a, forward_b, forward_c, nfForwardA, nfForwardB, nfForwardC;
  logic stall_if, stall_id, bubble_ex, mc_busy, mc_timeout;
  logic nfStallIf, nfStallId, nfBubbleEx, nfBusy, nfTimeout;
  logic [CW-1:0] stall_cycles, nfStallCycles;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.FWD_EN(1), .MAX_MC(MAXMC), .CNT_W(CW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_reg_write(id_reg_write),
    .id_mc_op(id_mc_op), .id_kill(id_kill),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alusrc(ex_alusrc), .ex_mc_start(ex_mc_start),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .mc_done(mc_done), .mc_rd(mc_rd),
    .forward_a(forward_a), .forward_b(forward_b), .forward_c(forward_c),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .mc_busy(mc_busy), .mc_timeout(mc_timeout), .stall_cycles(stall_cycles), .perf_clr(perf_clr)
  );

  hazard_fwd_unit #(.FWD_EN(0), .MAX_MC(MAXMC), .CNT_W(CW), .TIMEOUT_CYC(TMO)) dutNf (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_reg_write(id_reg_write),
    .id_mc_op(id_mc_op), .id_kill(id_kill),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alusrc(ex_alusrc), .ex_mc_start(ex_mc_start),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .mc_done(mc_done), .mc_rd(mc_rd),
    .forward_a(nfForwardA), .forward_b(nfForwardB), .forward_c(nfForwardC),
    .stall_if(nfStallIf), .stall_id(nfStallId), .bubble_ex(nfBubbleEx),
    .mc_busy(nfBusy), .mc_timeout(nfTimeout), .stall_cycles(nfStallCycles), .perf_clr(perf_clr)
  );

  int checks = 0;
  int failures = 0;

  // Reference state: pending flags per register, in-flight count, idle-cycle age, counters.
  bit pend[32];
  int outCnt, wdAge, stallCnt, stallCntNf;
  bit tmo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    foreach (pend[i]) pend[i] = 1'b0;
    outCnt = 0; wdAge = 0; tmo = 1'b0; stallCnt = 0; stallCntNf = 0;
  endtask

  task automatic clr();
    {id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd, mc_rd} = '0;
    {id_rs1_used, id_rs2_used, id_reg_write, id_mc_op, id_kill} = '0;
    {ex_reg_write, ex_mem_read, ex_mem_write, ex_alusrc, ex_mc_start} = '0;
    {mem_reg_write, wb_reg_write, mc_done, perf_clr} = '0;
  endtask

  function automatic bit reads(input logic [4:0] r);
    return (r != 0) && ((id_rs1_used && id_rs1 == r) || (id_rs2_used && id_rs2 == r));
  endfunction

  function automatic bit expStall(input bit fwdEn);
    bit s;
    if (id_kill) return 1'b0;
    s = ex_mem_read && reads(ex_rd);
    s = s || (ex_mc_start && (reads(ex_rd) || (id_reg_write && id_rd == ex_rd)));
    s = s || (id_rs1_used && pend[id_rs1]) || (id_rs2_used && pend[id_rs2]) || (id_reg_write && pend[id_rd]);
    s = s || (id_mc_op && (outCnt + int'(ex_mc_start) >= MAXMC));
    if (!fwdEn)
      s = s || (ex_reg_write && reads(ex_rd)) || (mem_reg_write && reads(mem_rd)) || (wb_reg_write && reads(wb_rd));
    return s;
  endfunction

  function automatic logic [1:0] expFwd(input logic [4:0] rs, input bit enable);
    if (!enable) return 2'd0;
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'd1;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  // Called just after a falling edge with inputs applied; returns after the next falling edge.
  task automatic cycle();
    bit s, sNf, dv;
    #1;
    s = expStall(1'b1);
    sNf = expStall(1'b0);
    chk("forward_a", 32'(forward_a), 32'(expFwd(ex_rs1, 1'b1)));
    chk("forward_b", 32'(forward_b), 32'(expFwd(ex_rs2, !ex_alusrc)));
    chk("forward_c", 32'(forward_c), 32'(expFwd(ex_rs2, ex_mem_write)));
    chk("stall_if", 32'(stall_if), 32'(s));
    chk("stall_id", 32'(stall_id), 32'(s));
    chk("bubble_ex", 32'(bubble_ex), 32'(s));
    chk("nofwd_selects", 32'({nfForwardA, nfForwardB, nfForwardC}), 32'd0);
    chk("nofwd_stall", 32'({nfStallIf, nfStallId, nfBubbleEx}), 32'(sNf ? 3'b111 : 3'b000));
    dv = mc_done && outCnt > 0;
    if (outCnt > 0 && !mc_done) begin
      wdAge++;
      if (wdAge >= TMO) tmo = 1'b1;
    end else begin
      wdAge = 0;
    end
    if (dv) pend[mc_rd] = 1'b0;
    if (ex_mc_start && ex_rd != 0) pend[ex_rd] = 1'b1;
    outCnt = outCnt + int'(ex_mc_start) - int'(dv);
    if (perf_clr) stallCnt = 0; else if (s && stallCnt < CNTMAX) stallCnt++;
    if (perf_clr) stallCntNf = 0; else if (sNf && stallCntNf < CNTMAX) stallCntNf++;
    @(posedge clk);
    @(negedge clk);
    chk("mc_busy", 32'(mc_busy), 32'(outCnt != 0));
    chk("mc_timeout", 32'(mc_timeout), 32'(tmo));
    chk("stall_cycles", 32'(stall_cycles), 32'(stallCnt));
    chk("nofwd_busy_tmo", 32'({nfBusy, nfTimeout}), 32'({outCnt != 0, tmo}));
    chk("nofwd_stall_cycles", 32'(nfStallCycles), 32'(stallCntNf));
  endtask

  initial begin
    clr();
    modelReset();
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_stall_cycles", 32'(stall_cycles), 32'd0);
    chk("reset_busy", 32'(mc_busy), 32'd0);
    chk("reset_timeout", 32'(mc_timeout), 32'd0);
    chk("reset_stall", 32'(stall_if), 32'd0);
    rst_n = 1'b1;

    // Bypass priority and x0 exclusion
    mem_rd = 5; mem_reg_write = 1; wb_rd = 5; wb_reg_write = 1; ex_rs1 = 5;
    cycle();
    chk("tp_fwd_mem_priority", 32'(forward_a), 32'd1);
    mem_reg_write = 0;
    cycle();
    chk("tp_fwd_wb_only", 32'(forward_a), 32'd2);
    mem_rd = 0; wb_rd = 0; mem_reg_write = 1; ex_rs1 = 0;
    cycle();
    chk("tp_fwd_x0", 32'(forward_a), 32'd0);

    // Store data bypass ignores alusrc
    clr(); ex_alusrc = 1; ex_mem_write = 1; mem_rd = 7; mem_reg_write = 1; ex_rs2 = 7;
    cycle();
    chk("tp_store_fwd_b", 32'(forward_b), 32'd0);
    chk("tp_store_fwd_c", 32'(forward_c), 32'd1);

    // Load-use: one stall cycle, then the bubble reaches EX
    clr(); ex_mem_read = 1; ex_reg_write = 1; ex_rd = 3; id_rs2 = 3; id_rs2_used = 1;
    cycle();
    chk("tp_loaduse_count", 32'(stall_cycles), 32'd1);
    ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0;
    cycle();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 3; id_kill = 1;
    cycle();

    // MC op on x9 with a dependent in ID
    clr(); ex_mc_start = 1; ex_rd = 9; id_rs1 = 9; id_rs1_used = 1;
    cycle();
    ex_mc_start = 0; ex_rd = 0;
    repeat (3) cycle();
    mc_done = 1; mc_rd = 9;
    cycle();
    mc_done = 0;
    cycle();
    chk("tp_mc_released", 32'(stall_if), 32'd0);

    // Full MC unit and same-cycle done/start on one register
    clr(); ex_mc_start = 1; ex_rd = 10;
    cycle();
    ex_rd = 11;
    cycle();
    ex_mc_start = 0; ex_rd = 0; id_mc_op = 1;
    cycle();
    id_mc_op = 0; mc_done = 1; mc_rd = 10; ex_mc_start = 1; ex_rd = 10;
    cycle();
    clr(); id_rs1 = 10; id_rs1_used = 1;
    cycle();
    chk("tp_set_wins", 32'(stall_if), 32'd1);
    clr(); mc_done = 1; mc_rd = 10;
    cycle();
    mc_rd = 11;
    cycle();
    mc_done = 0;
    cycle();

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7)); id_rd = 5'($urandom_range(0, 7));
      ex_rs1 = 5'($urandom_range(0, 7)); ex_rs2 = 5'($urandom_range(0, 7)); ex_rd = 5'($urandom_range(0, 7));
      mem_rd = 5'($urandom_range(0, 7)); wb_rd = 5'($urandom_range(0, 7)); mc_rd = 5'($urandom_range(0, 7));
      id_rs1_used = 1'($urandom_range(0, 1)); id_rs2_used = 1'($urandom_range(0, 1));
      id_reg_write = 1'($urandom_range(0, 1)); id_mc_op = ($urandom_range(0, 3) == 0);
      id_kill = ($urandom_range(0, 7) == 0);
      ex_reg_write = 1'($urandom_range(0, 1)); ex_mem_read = ($urandom_range(0, 3) == 0);
      ex_mem_write = 1'($urandom_range(0, 1)); ex_alusrc = 1'($urandom_range(0, 1));
      mem_reg_write = 1'($urandom_range(0, 1)); wb_reg_write = 1'($urandom_range(0, 1));
      mc_done = ($urandom_range(0, 3) == 0);
      ex_mc_start = ($urandom_range(0, 3) == 0) && (outCnt < MAXMC || (mc_done && outCnt > 0));
      perf_clr = ($urandom_range(0, 31) == 0);
      cycle();
    end

    // Watchdog: one op stuck for TIMEOUT_CYC cycles
    clr(); rst_n = 1'b0; #1; rst_n = 1'b1; modelReset();
    @(negedge clk);
    ex_mc_start = 1; ex_rd = 12;
    cycle();
    ex_mc_start = 0; ex_rd = 0;
    repeat (TMO - 1) cycle();
    chk("tp_tmo_not_yet", 32'(mc_timeout), 32'd0);
    cycle();
    chk("tp_tmo_set", 32'(mc_timeout), 32'd1);
    mc_done = 1; mc_rd = 12;
    cycle();
    mc_done = 0;
    repeat (3) cycle();
    chk("tp_tmo_sticky", 32'(mc_timeout), 32'd1);

    // Asynchronous reset mid-operation
    ex_mc_start = 1; ex_rd = 13; id_rs1 = 13; id_rs1_used = 1;
    cycle();
    clr();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(mc_busy), 32'd0);
    chk("async_rst_tmo", 32'(mc_timeout), 32'd0);
    chk("async_rst_cnt", 32'(stall_cycles), 32'd0);
    #1 rst_n = 1'b1;
    modelReset();
    @(negedge clk);

    // Stall counter saturation and clear priority
    ex_mem_read = 1; ex_rd = 3; id_rs1 = 3; id_rs1_used = 1;
    repeat (CNTMAX + 3) cycle();
    chk("tp_cnt_saturated", 32'(stall_cycles), 32'(CNTMAX));
    perf_clr = 1;
    cycle();
    chk("tp_cnt_clear", 32'(stall_cycles), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
